// File: rtl/elevator_ctrl.sv
// Elevator shaft controller: closes the doors, steps the car between floor 0 and 3,
// then reopens the doors. Every command is a registered single-cycle pulse.
module elevator_ctrl #(
    parameter int STEP_GAP        = 4,
    parameter int CONFIRM_TIMEOUT = 16,
    parameter int DWELL           = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       GU,
    input  logic       GL,
    input  logic       CU,
    input  logic       CL,
    input  logic       UES,
    input  logic       LES,
    input  logic       IS,
    input  logic       AU,
    input  logic       AL,
    input  logic [1:0] floor,
    output logic       MU,
    output logic       MD,
    output logic       CUE,
    output logic       OUE,
    output logic       CLE,
    output logic       OLE,
    output logic       CI,
    output logic       OI,
    output logic       busy,
    output logic       fault
);

    typedef enum logic [3:0] {
        IDLE, CLOSE_OUTER, WAIT_OUTER, CLOSE_INNER, WAIT_INNER, STEP, WAIT_FLOOR,
        GAP, OPEN_OUTER, WAIT_OPEN_OUTER, OPEN_INNER, WAIT_OPEN_INNER, DWELL_ST, FAULT
    } state_t;

    localparam logic [7:0] GAP_LIM   = 8'(STEP_GAP - 1);
    localparam logic [7:0] TO_LIM    = 8'(CONFIRM_TIMEOUT - 1);
    localparam logic [7:0] DWELL_LIM = 8'(DWELL - 1);

    // Command vector bit order: {MU, MD, CUE, OUE, CLE, OLE, CI, OI}
    state_t     r_state;
    state_t     w_next;
    logic       r_up;
    logic       w_up;
    logic [7:0] r_cnt;
    logic [1:0] r_floorCap;
    logic [7:0] r_cmd;
    logic [7:0] w_cmd;
    logic       w_timeout;
    logic       w_wrap;

    function automatic state_t closeEntry(input logic outerOpen, input logic innerOpen);
        if (outerOpen)      return CLOSE_OUTER;
        else if (innerOpen) return CLOSE_INNER;
        else                return STEP;
    endfunction

    assign w_timeout = (r_cnt == TO_LIM);
    assign w_wrap    = r_up ? (r_floorCap == 2'd3 && floor == 2'd0)
                            : (r_floorCap == 2'd0 && floor == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_up       <= 1'b0;
            r_cnt      <= '0;
            r_floorCap <= '0;
            r_cmd      <= '0;
        end else begin
            r_state <= w_next;
            r_up    <= w_up;
            r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
            if (r_state == STEP)
                r_floorCap <= floor;
            r_cmd   <= w_cmd;
        end
    end

    // Pulses are decoded from the state being entered, so each lands in its own one-cycle state.
    always_comb begin
        w_next = r_state;
        w_up   = r_up;
        w_cmd  = '0;
        case (r_state)
            IDLE: begin
                if (AL && (GU || CU)) begin
                    w_up   = 1'b1;
                    w_next = closeEntry(LES, IS);
                end else if (AU && (GL || CL)) begin
                    w_up   = 1'b0;
                    w_next = closeEntry(UES, IS);
                end else if (!AU && !AL) begin
                    w_up   = 1'b0;
                    w_next = closeEntry(UES, IS);
                end
            end
            CLOSE_OUTER: w_next = WAIT_OUTER;
            WAIT_OUTER: begin
                if (!(r_up ? LES : UES)) w_next = IS ? CLOSE_INNER : STEP;
                else if (w_timeout)     w_next = FAULT;
            end
            CLOSE_INNER: w_next = WAIT_INNER;
            WAIT_INNER: begin
                if (!IS)            w_next = STEP;
                else if (w_timeout) w_next = FAULT;
            end
            STEP: w_next = WAIT_FLOOR;
            WAIT_FLOOR: begin
                if (floor != r_floorCap) w_next = w_wrap ? FAULT : GAP;
                else if (w_timeout)      w_next = FAULT;
            end
            GAP: begin
                if (r_cnt == GAP_LIM) w_next = (r_up ? AU : AL) ? OPEN_OUTER : STEP;
            end
            OPEN_OUTER: w_next = WAIT_OPEN_OUTER;
            WAIT_OPEN_OUTER: begin
                if (r_up ? UES : LES) w_next = OPEN_INNER;
                else if (w_timeout)   w_next = FAULT;
            end
            OPEN_INNER: w_next = WAIT_OPEN_INNER;
            WAIT_OPEN_INNER: begin
                if (IS)             w_next = DWELL_ST;
                else if (w_timeout) w_next = FAULT;
            end
            DWELL_ST: begin
                if (r_cnt == DWELL_LIM) w_next = IDLE;
            end
            FAULT:   w_next = FAULT;
            default: w_next = FAULT;
        endcase

        if (AU && AL)
            w_next = FAULT;

        case (w_next)
            CLOSE_OUTER: w_cmd = w_up ? 8'h08 : 8'h20;
            CLOSE_INNER: w_cmd = 8'h02;
            STEP:        w_cmd = w_up ? 8'h80 : 8'h40;
            OPEN_OUTER:  w_cmd = w_up ? 8'h10 : 8'h04;
            OPEN_INNER:  w_cmd = 8'h01;
            default:     w_cmd = 8'h00;
        endcase
    end

    assign {MU, MD, CUE, OUE, CLE, OLE, CI, OI} = r_cmd;
    assign busy  = (r_state != IDLE) && (r_state != FAULT);
    assign fault = (r_state == FAULT);

endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: a small transducer model drives the sensors, and a
// scoreboard compares every command pulse against a queue of expected commands.
module tb_elevator_ctrl;

    localparam logic [7:0] C_MU  = 8'h80, C_MD  = 8'h40, C_CUE = 8'h20, C_OUE = 8'h10;
    localparam logic [7:0] C_CLE = 8'h08, C_OLE = 8'h04, C_CI  = 8'h02, C_OI  = 8'h01;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       GU, GL, UES, LES, IS, AU, AL;
    logic       CU = 1'b0, CL = 1'b0;
    logic [1:0] floor;
    logic       MU, MD, CUE, OUE, CLE, OLE, CI, OI, busy, fault;
    logic [7:0] cmdVec;

    logic [1:0] mFloor = 2'd0;
    logic       mUes = 1'b0, mLes = 1'b0, mIs = 1'b0, mGu = 1'b0, mGl = 1'b0;
    logic       guPb = 1'b0, glPb = 1'b0, stuckUes = 1'b0, forceAuAl = 1'b0;

    int         cyc = 0;
    int         nVec = 0;
    int         nErr = 0;
    int         moveId = 0;
    logic [7:0] expQ[$];

    elevator_ctrl dut (
        .clk(clk), .reset(reset), .GU(GU), .GL(GL), .CU(CU), .CL(CL),
        .UES(UES), .LES(LES), .IS(IS), .AU(AU), .AL(AL), .floor(floor),
        .MU(MU), .MD(MD), .CUE(CUE), .OUE(OUE), .CLE(CLE), .OLE(OLE),
        .CI(CI), .OI(OI), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cmdVec = {MU, MD, CUE, OUE, CLE, OLE, CI, OI};
    assign floor  = mFloor;
    assign UES    = mUes | stuckUes;
    assign LES    = mLes;
    assign IS     = mIs;
    assign GU     = mGu;
    assign GL     = mGl;
    assign AU     = (mFloor == 2'd3) | forceAuAl;
    assign AL     = (mFloor == 2'd0) | forceAuAl;

    // Transducers react one cycle after each pulse; calls clear once the car moves.
    always @(posedge clk) begin
        if (MU)      mFloor <= mFloor + 2'd1;
        else if (MD) mFloor <= mFloor - 2'd1;
        if (CUE)      mUes <= 1'b0;
        else if (OUE) mUes <= 1'b1;
        if (CLE)      mLes <= 1'b0;
        else if (OLE) mLes <= 1'b1;
        if (CI)      mIs <= 1'b0;
        else if (OI) mIs <= 1'b1;
        if (guPb)          mGu <= 1'b1;
        else if (MU || MD) mGu <= 1'b0;
        if (glPb)          mGl <= 1'b1;
        else if (MU || MD) mGl <= 1'b0;
    end

    task automatic checkOutput(input string name, input int got, input int want);
        nVec++;
        if (got != want) begin
            nErr++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic checkWindow(input string name, input int got, input int lo, input int hi);
        nVec++;
        if (got < lo || got > hi) begin
            nErr++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Scoreboard: pops one expected command per observed pulse and checks step spacing.
    task automatic monitorLoop();
        int         lastStep = -1;
        int         lastMove = 0;
        logic [7:0] exp;
        forever begin
            @(negedge clk);
            if (moveId != lastMove) begin
                lastMove = moveId;
                lastStep = -1;
            end
            if (cmdVec != 8'h00) begin
                checkOutput("oneHot", $countones(cmdVec), 1);
                nVec++;
                if (expQ.size() == 0) begin
                    nErr++;
                    $display("[TB] FAIL unexpectedCmd: got %02h, expected none", cmdVec);
                end else begin
                    exp = expQ.pop_front();
                    if (exp != cmdVec) begin
                        nErr++;
                        $display("[TB] FAIL cmdSeq: got %02h, expected %02h", cmdVec, exp);
                    end
                end
                if (MU || MD) begin
                    if (lastStep >= 0)
                        checkOutput("stepSpacing", cyc - lastStep, 6);
                    lastStep = cyc;
                end
            end
        end
    endtask

    task automatic pushMany(input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) expQ.push_back(c);
    endtask

    task automatic applyStimulus(input logic up, input logic down);
        moveId++;
        @(negedge clk);
        guPb = up;
        glPb = down;
        @(negedge clk);
        guPb = 1'b0;
        glPb = 1'b0;
    endtask

    task automatic waitCmd(input string name, input logic [7:0] mask, output int atCyc);
        atCyc = -1;
        for (int n = 0; n < 200 && atCyc < 0; n++) begin
            @(negedge clk);
            if ((cmdVec & mask) != 8'h00) atCyc = cyc;
        end
        if (atCyc < 0) begin
            nVec++;
            nErr++;
            $display("[TB] FAIL %s: got no pulse, expected one within 200 cycles", name);
        end
    endtask

    // Waits for a full busy period; reports cycles from the inner door opening to busy falling.
    task automatic waitSeq(input string name, output int fallDelay);
        logic prevIs = IS;
        bit   seenBusy = 0;
        bit   done = 0;
        int   isRise = -1000;
        fallDelay = -1;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge clk);
            if (IS && !prevIs) isRise = cyc;
            prevIs = IS;
            if (busy) seenBusy = 1;
            else if (seenBusy) begin
                done = 1;
                fallDelay = cyc - isRise;
            end
        end
        if (!done) begin
            nVec++;
            nErr++;
            $display("[TB] FAIL %s: got busy period unfinished, expected done within 400 cycles", name);
        end
    endtask

    initial begin
        int delay;
        int at;
        int anyCmd;
        fork
            monitorLoop();
        join_none

        repeat (3) @(negedge clk);
        checkOutput("resetCmd", int'(cmdVec), 0);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetFault", int'(fault), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idleBusy", int'(busy), 0);

        // Up trip from floor 0 with doors closed: no close pulses.
        pushMany(C_MU, 3); pushMany(C_OUE, 1); pushMany(C_OI, 1);
        applyStimulus(1'b1, 1'b0);
        waitSeq("upTrip", delay);
        checkWindow("upDwell", delay, 8, 9);
        checkOutput("upFloor", int'(mFloor), 3);
        checkOutput("upUes", int'(UES), 1);
        checkOutput("upIs", int'(IS), 1);
        checkOutput("upQueue", expQ.size(), 0);

        // Down trip from floor 3 with upper and inner doors open.
        pushMany(C_CUE, 1); pushMany(C_CI, 1); pushMany(C_MD, 3);
        pushMany(C_OLE, 1); pushMany(C_OI, 1);
        applyStimulus(1'b0, 1'b1);
        waitSeq("downTrip", delay);
        checkOutput("downFloor", int'(mFloor), 0);
        checkOutput("downLes", int'(LES), 1);
        checkOutput("downUes", int'(UES), 0);
        checkOutput("downIs", int'(IS), 1);
        checkOutput("downBusy", int'(busy), 0);
        checkOutput("downQueue", expQ.size(), 0);

        // Both calls at floor 0: position wins, only the up trip runs.
        pushMany(C_CLE, 1); pushMany(C_CI, 1); pushMany(C_MU, 3);
        pushMany(C_OUE, 1); pushMany(C_OI, 1);
        applyStimulus(1'b1, 1'b1);
        waitSeq("bothCalls", delay);
        checkOutput("bothFloor", int'(mFloor), 3);
        checkOutput("bothQueue", expQ.size(), 0);

        // Upper door stuck open: one CUE, then timeout fault 16 cycles into WAIT_OUTER.
        stuckUes = 1'b1;
        pushMany(C_CUE, 1);
        applyStimulus(1'b0, 1'b1);
        waitCmd("stuckCue", C_CUE, at);
        repeat (16) @(negedge clk);
        checkOutput("faultEarly", int'(fault), 0);
        @(negedge clk);
        checkOutput("faultTimeout", int'(fault), 1);
        checkOutput("faultBusy", int'(busy), 0);
        repeat (30) @(negedge clk);
        checkOutput("faultSticky", int'(fault), 1);
        checkOutput("faultQueue", expQ.size(), 0);

        // Reset clears the fault; the still-latched down call then runs with UES already closed.
        reset = 1'b1;
        @(negedge clk);
        checkOutput("faultCleared", int'(fault), 0);
        stuckUes = 1'b0;
        pushMany(C_CI, 1); pushMany(C_MD, 3); pushMany(C_OLE, 1); pushMany(C_OI, 1);
        moveId++;
        @(negedge clk);
        reset = 1'b0;
        waitSeq("recoverTrip", delay);
        checkOutput("recoverFloor", int'(mFloor), 0);
        checkOutput("recoverQueue", expQ.size(), 0);

        // Reset one cycle after the first MU aborts the trip; mid-shaft recovery heads down.
        pushMany(C_CLE, 1); pushMany(C_CI, 1); pushMany(C_MU, 1);
        applyStimulus(1'b1, 1'b0);
        waitCmd("abortMu", C_MU, at);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abortCmd", int'(cmdVec), 0);
        checkOutput("abortBusy", int'(busy), 0);
        checkOutput("abortFault", int'(fault), 0);
        checkOutput("abortFloor", int'(mFloor), 1);
        pushMany(C_MD, 1); pushMany(C_OLE, 1); pushMany(C_OI, 1);
        moveId++;
        reset = 1'b0;
        waitSeq("abortRecover", delay);
        checkOutput("abortRecFloor", int'(mFloor), 0);
        checkOutput("abortQueue", expQ.size(), 0);

        // AU and AL together while idle: fault on the next cycle, commands stay quiet.
        @(negedge clk);
        forceAuAl = 1'b1;
        @(negedge clk);
        checkOutput("dualFault", int'(fault), 1);
        checkOutput("dualBusy", int'(busy), 0);
        anyCmd = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmdVec != 8'h00) anyCmd++;
        end
        checkOutput("dualQuiet", anyCmd, 0);
        checkOutput("dualSticky", int'(fault), 1);
        checkOutput("finalQueue", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
